// File: rtl/booth_seq_mul4.sv
// -----------------------------------------------------------------------------
// booth_seq_mul4
//
// Sequential radix-2 Booth multiplier for 4-bit two's-complement operands that
// produces an exact 8-bit signed product. It takes one operand pair per
// valid/ready handshake and performs one Booth step per clock, four steps in
// all. It then holds the result in DONE until the consumer takes it.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operand pair valid
//   in_ready   out  1   block can accept operands (IDLE only)
//   md         in   4   signed multiplicand
//   mr         in   4   signed multiplier
//   out_valid  out  1   product valid (DONE)
//   out_ready  in   1   consumer accepts product
//   product    out  8   signed product md*mr, held until the next load
//   busy       out  1   high in RUN or DONE
//
// Optional feature (macro BOOTH_SEQ_EARLY_TERM_EN):
//   When the macro is defined and either operand is zero at accept, RUN is
//   skipped. The block goes straight to DONE with product = 0, so the latency
//   is 1 cycle.
// -----------------------------------------------------------------------------
module booth_seq_mul4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] md,
  input  logic [3:0] mr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] product,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q,   state_d;
  logic [4:0] a_q,       a_d;       // accumulator, one extra bit so -M fits for md=-8
  logic [3:0] q_q,       q_d;       // multiplier, shifted right each step
  logic       qm1_q,     qm1_d;     // previous multiplier LSB
  logic [4:0] m_q,       m_d;       // sign-extended multiplicand
  logic [1:0] cnt_q,     cnt_d;     // step counter
  logic [7:0] product_q, product_d;

  // Accumulator after the add/subtract of this step and before the shift.
  logic [4:0] a_sum;

  always_comb begin
    a_sum = a_q;
    case ({q_q[0], qm1_q})
      2'b01:   a_sum = a_q + m_q;
      2'b10:   a_sum = a_q - m_q;
      default: a_sum = a_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = 5'd0;
          q_d     = mr;
          qm1_d   = 1'b0;
          m_d     = {md[3], md};
          cnt_d   = 2'd0;
          state_d = S_RUN;
`ifdef BOOTH_SEQ_EARLY_TERM_EN
          // A zero operand always gives a zero product, so skip the steps.
          if ((md == 4'd0) || (mr == 4'd0)) begin
            product_d = 8'h00;
            state_d   = S_DONE;
          end
`endif
        end
      end

      S_RUN: begin
        // Arithmetic shift right of {A,Q,q_m1}. A[4] is replicated into the
        // top bit, and A's LSB moves into the top of Q.
        a_d   = {a_sum[4], a_sum[4:1]};
        q_d   = {a_sum[0], q_q[3:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          // The result range -56..64 fits in 8 bits, so A[4] is only a sign
          // copy and is dropped.
          product_d = {a_d[3:0], q_d};
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= 5'd0;
      q_q       <= 4'd0;
      qm1_q     <= 1'b0;
      m_q       <= 5'd0;
      cnt_q     <= 2'd0;
      product_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign product   = product_q;

endmodule

// File: tb/tb_booth_seq_mul4.sv
// -----------------------------------------------------------------------------
// tb_booth_seq_mul4
//
// Self-checking bench for booth_seq_mul4. It runs a table of directed vectors,
// a reset-abort sequence, an exhaustive sweep of all 256 operand pairs, and
// randomized operations with random backpressure. Every product is compared
// with a plain signed-multiply reference, and every latency with the expected
// value for the build.
// -----------------------------------------------------------------------------
module tb_booth_seq_mul4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] md;
  logic [3:0] mr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] product;
  logic       busy;

  int errors = 0;
  int checks = 0;

  booth_seq_mul4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .md        (md),
    .mr        (mr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
    int         hold;
    bit         junk;
  } vec_t;

  vec_t vecs[9];

  // Reference: plain signed multiply, truncated to 8 bits.
  function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
    int ia;
    int ib;
    int p;
    ia = int'($signed(a));
    ib = int'($signed(b));
    p  = ia * ib;
    return p[7:0];
  endfunction

  function automatic int exp_latency(input logic [3:0] a, input logic [3:0] b);
`ifdef BOOTH_SEQ_EARLY_TERM_EN
    if ((a == 4'd0) || (b == 4'd0)) return 1;
`endif
    return 5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full transaction. hold = cycles out_ready stays low once out_valid is
  // up. junk = keep in_valid high and scramble md/mr while the operation runs.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp_p,
                       input int hold, input bit junk, input string tag);
    int  cyc;
    bit  seen;
    logic [7:0] held;
    @(negedge clk);
    chk({tag, " in_ready_idle"}, in_ready, 1);
    md        = a;
    mr        = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    if (!junk) in_valid = 1'b0;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (out_valid) seen = 1;
      else begin
        if (cyc == 1) begin
          chk({tag, " in_ready_run"}, in_ready, 0);
          chk({tag, " busy_run"}, busy, 1);
        end
        if (junk) begin
          md = 4'($urandom);
          mr = 4'($urandom);
        end
      end
    end
    in_valid = 1'b0;
    chk({tag, " out_valid_seen"}, seen, 1);
    chk({tag, " latency"}, cyc, exp_latency(a, b));
    chk({tag, " product"}, product, exp_p);
    $display("op %s md=%0d mr=%0d product=%02h latency=%0d", tag, $signed(a), $signed(b), product, cyc);
    held = product;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold_valid"}, out_valid, 1);
      chk({tag, " hold_product"}, product, held);
      chk({tag, " hold_in_ready"}, in_ready, 0);
      chk({tag, " hold_busy"}, busy, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, " out_valid_fall"}, out_valid, 0);
    chk({tag, " in_ready_back"}, in_ready, 1);
    chk({tag, " product_kept"}, product, held);
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'h3, 4'h5, 8'h0F, 0, 1'b0};
    vecs[1] = '{4'h8, 4'h8, 8'h40, 0, 1'b0};
    vecs[2] = '{4'h8, 4'h7, 8'hC8, 0, 1'b0};
    vecs[3] = '{4'h7, 4'hF, 8'hF9, 0, 1'b0};
    vecs[4] = '{4'h2, 4'hD, 8'hFA, 3, 1'b0};
    vecs[5] = '{4'h0, 4'hD, 8'h00, 0, 1'b0};
    vecs[6] = '{4'hF, 4'hF, 8'h01, 0, 1'b1};
    vecs[7] = '{4'h9, 4'h6, 8'hD6, 1, 1'b1};
    vecs[8] = '{4'h4, 4'h0, 8'h00, 2, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    md        = 4'd0;
    mr        = 4'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset product", product, 8'h00);
    chk("reset busy", busy, 0);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold, vecs[i].junk, $sformatf("vec%0d", i));
    end

    // Reset asserted during the third RUN cycle aborts the operation.
    begin
      bit rose;
      @(negedge clk);
      md        = 4'h5;
      mr        = 4'h6;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #2;
      chk("abort product", product, 8'h00);
      chk("abort out_valid", out_valid, 0);
      chk("abort in_ready", in_ready, 1);
      chk("abort busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      rose  = 0;
      repeat (8) begin
        @(negedge clk);
        if (out_valid) rose = 1;
      end
      chk("abort no_out_valid", rose, 0);
      chk("abort product_after", product, 8'h00);
      $display("op abort md=5 mr=6 reset in RUN, product=%02h", product);
      out_ready = 1'b0;
      do_op(4'h1, 4'h1, 8'h01, 0, 1'b0, "after_abort");
    end

    // Exhaustive sweep
    for (int i = 0; i < 256; i++) begin
      logic [7:0] pair;
      pair = 8'(i);
      do_op(pair[7:4], pair[3:0], ref_mul(pair[7:4], pair[3:0]), 0, 1'b0, "sweep");
    end

    // Randomized operations with random backpressure and idle gaps
    for (int i = 0; i < 60; i++) begin
      logic [3:0] ra;
      logic [3:0] rb;
      ra = 4'($urandom);
      rb = 4'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(ra, rb, ref_mul(ra, rb), $urandom_range(0, 3), 1'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
